// File: rtl/sliding_window_gen_pkg.sv
// Window packing shared by the sliding-window generator and the convolution stage.
// Element (r,c) of an NxN window sits at bit offset ((r*N)+c)*BitSize, r=0 top row, c=0 leftmost.
package sliding_window_gen_pkg;

  localparam int unsigned DEF_N       = 3;
  localparam int unsigned DEF_BITSIZE = 8;

  // One element per packed slot; slot index r*N+c.
  typedef logic [DEF_N*DEF_N-1:0][DEF_BITSIZE-1:0] window_t;

  function automatic int unsigned win_offset(
    input int unsigned r,
    input int unsigned c,
    input int unsigned n,
    input int unsigned bits
  );
    return ((r * n) + c) * bits;
  endfunction

endpackage

// File: rtl/sliding_window_gen_line_buffer.sv
// One image row of pixel storage, inferred as block RAM with a registered read port.
// Write and read run each cycle at independent addresses so the next column can be prefetched.
module line_buffer #(
  parameter int Depth = 16,
  parameter int Width = 8,
  parameter int AddrW = 4
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sliding_window_gen.sv
// Streams a raster image in and emits every fully-populated NxN window, with a
// valid/ready handshake on both sides and no padding at the image border.
module sliding_window_gen
  import sliding_window_gen_pkg::*;
#(
  parameter int N          = 3,
  parameter int BitSize    = 8,
  parameter int ImageWidth = 16
) (
  input  logic                      clk,
  input  logic                      res_n,
  input  logic                      in_valid,
  input  logic [BitSize-1:0]        in_data,
  output logic                      in_ready,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [(N*N)*BitSize-1:0]  out_data
);

  localparam int CW   = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
  localparam int WinW = N * N * BitSize;
  localparam logic [CW-1:0] LastPos    = CW'(ImageWidth - 1);
  localparam logic [CW-1:0] FirstValid = CW'(N - 1);

  logic [CW-1:0]      col_q, col_d;
  logic [CW-1:0]      row_q, row_d;
  logic               out_valid_q, out_valid_d;
  logic [WinW-1:0]    win_q;
  logic [WinW-1:0]    win_d;
  logic               accept;
  logic               valid_pos;
  logic [BitSize-1:0] lb_rd  [N-1];
  logic [BitSize-1:0] lb_wr  [N-1];
  logic [BitSize-1:0] new_col [N];

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign valid_pos = (row_q >= FirstValid) && (col_q >= FirstValid);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == LastPos) begin
        col_d = '0;
        row_d = (row_q == LastPos) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // A held window stays until taken; a new one replaces it only on a valid-position pixel.
  assign out_valid_d = accept ? valid_pos : (out_valid_q && !out_ready);

  // Buffer 0 holds the previous row, buffer N-2 the oldest. The read port is aimed
  // at col_d so the next pixel's column data is already registered when it arrives.
  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_wr[gi] = in_data;
      end else begin : g_shift
        assign lb_wr[gi] = lb_rd[gi-1];
      end

      line_buffer #(
        .Depth (ImageWidth),
        .Width (BitSize),
        .AddrW (CW)
      ) u_line_buffer (
        .clk       (clk),
        .wr_en_i   (accept),
        .wr_addr_i (col_q),
        .wr_data_i (lb_wr[gi]),
        .rd_addr_i (col_d),
        .rd_data_o (lb_rd[gi])
      );
    end

    for (gi = 0; gi < N; gi++) begin : g_newcol
      if (gi < N - 1) begin : g_from_lb
        assign new_col[gi] = lb_rd[N-2-gi];
      end else begin : g_from_in
        assign new_col[gi] = in_data;
      end
    end

    for (gi = 0; gi < N * N; gi++) begin : g_win
      localparam int unsigned R   = gi / N;
      localparam int unsigned C   = gi % N;
      localparam int unsigned Ofs = win_offset(R, C, N, BitSize);
      if (C < N - 1) begin : g_shl
        assign win_d[Ofs +: BitSize] = win_q[win_offset(R, C + 1, N, BitSize) +: BitSize];
      end else begin : g_load
        assign win_d[Ofs +: BitSize] = new_col[R];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      win_q       <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      // Shift on every accepted pixel so columns line up once valid positions resume.
      if (accept) begin
        win_q <= win_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = win_q;

endmodule

// File: tb/tb_sliding_window_gen.sv
// Scoreboard bench: expected windows are built from the accepted pixel image and
// compared in order on each output transfer; two instances cover 4x4 and 16x16 images.
module tb_sliding_window_gen;
  import sliding_window_gen_pkg::*;

  localparam int N  = 3;
  localparam int BS = 8;
  localparam int WW = N * N * BS;

  logic          clk = 1'b0;
  logic          res_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [BS-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          use16 = 1'b0;

  logic          rdy4, ov4, rdy16, ov16;
  logic [WW-1:0] od4, od16;
  logic          cur_rdy, cur_ov;
  logic [WW-1:0] cur_od;

  assign cur_rdy = use16 ? rdy16 : rdy4;
  assign cur_ov  = use16 ? ov16  : ov4;
  assign cur_od  = use16 ? od16  : od4;

  always #5 clk = ~clk;

  sliding_window_gen #(.N(N), .BitSize(BS), .ImageWidth(4)) u_dut4 (
    .clk       (clk),
    .res_n     (res_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rdy4),
    .out_ready (out_ready),
    .out_valid (ov4),
    .out_data  (od4)
  );

  sliding_window_gen #(.N(N), .BitSize(BS), .ImageWidth(16)) u_dut16 (
    .clk       (clk),
    .res_n     (res_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rdy16),
    .out_ready (out_ready),
    .out_valid (ov16),
    .out_data  (od16)
  );

  int            n_checks = 0;
  int            n_pass = 0;
  window_t       sb [$];
  logic [BS-1:0] stim [$];
  logic [BS-1:0] img [16][16];
  int            iw = 4;
  int            pr = 0;
  int            pc = 0;
  bit            exp_ov = 1'b0;
  int            mode = 0;
  int            stall_left = 0;
  bit            prev_stall = 1'b0;
  logic [WW-1:0] prev_data = '0;
  int            win_cnt = 0;

  task automatic check_val(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_frame(input int base, input bit rnd, input int count);
    for (int i = 0; i < count; i++)
      stim.push_back(rnd ? BS'($urandom) : BS'(base + i));
  endtask

  task automatic cycle();
    window_t e;
    bit      acc;
    if (stim.size() > 0 && (mode != 2 || $urandom_range(0, 2) != 0)) begin
      in_valid = 1'b1;
      in_data  = stim[0];
    end else begin
      in_valid = 1'b0;
      in_data  = BS'($urandom);
    end
    if (mode == 2) out_ready = ($urandom_range(0, 2) != 0);
    else if (mode == 1 && cur_ov && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else out_ready = 1'b1;

    @(negedge clk);
    check_val("in_ready", WW'(cur_rdy), WW'(!cur_ov || out_ready));
    check_val("out_valid", WW'(cur_ov), WW'(exp_ov));
    if (prev_stall) check_val("stall_hold", cur_od, prev_data);
    acc = in_valid && cur_rdy;
    if (cur_ov && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      check_val("window", cur_od, e);
      $display("window %0d dut=%h exp=%h", win_cnt, cur_od, e);
      win_cnt++;
    end
    prev_stall = cur_ov && !out_ready;
    prev_data  = cur_od;
    if (acc) begin
      img[pr][pc] = in_data;
      void'(stim.pop_front());
      exp_ov = (pr >= N - 1) && (pc >= N - 1);
      if (exp_ov) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            e[r*N + c] = img[pr-N+1+r][pc-N+1+c];
        sb.push_back(e);
      end
      pc++;
      if (pc == iw) begin
        pc = 0;
        pr++;
        if (pr == iw) pr = 0;
      end
    end else begin
      exp_ov = exp_ov && !out_ready;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((stim.size() > 0 || sb.size() > 0 || exp_ov) && n < budget) begin
      cycle();
      n++;
    end
    check_val("drained", WW'(stim.size() + sb.size()), WW'(0));
  endtask

  task automatic do_reset();
    res_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("rst_out_valid", WW'(cur_ov), WW'(0));
    check_val("rst_in_ready", WW'(cur_rdy), WW'(1));
    check_val("rst_out_data", cur_od, WW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    res_n = 1'b1;
    #1;
    check_val("post_rst_in_ready", WW'(cur_rdy), WW'(1));
    @(posedge clk);
    #1;
    pr = 0; pc = 0; exp_ov = 1'b0; prev_stall = 1'b0;
    sb.delete();
    stim.delete();
  endtask

  initial begin
    #2;
    do_reset();

    // Continuous stream, single 4x4 frame.
    mode = 0; win_cnt = 0;
    push_frame(0, 1'b0, 16);
    run(200);
    check_val("win_count_basic", WW'(win_cnt), WW'(4));

    // Hold the first window for five cycles.
    mode = 1; stall_left = 5; win_cnt = 0;
    push_frame(0, 1'b0, 16);
    run(200);
    check_val("stall_cycles_used", WW'(stall_left), WW'(0));
    check_val("win_count_stall", WW'(win_cnt), WW'(4));

    // Two frames back to back.
    mode = 0; win_cnt = 0;
    push_frame(0, 1'b0, 16);
    push_frame(100, 1'b0, 16);
    run(300);
    check_val("win_count_2frames", WW'(win_cnt), WW'(8));

    // Reset after pixel 9, then a full frame.
    win_cnt = 0;
    push_frame(0, 1'b0, 10);
    run(100);
    do_reset();
    push_frame(0, 1'b0, 16);
    run(200);
    check_val("win_count_after_rst", WW'(win_cnt), WW'(4));

    // 16x16, random handshakes, two random frames.
    use16 = 1'b1; iw = 16; mode = 2; win_cnt = 0;
    do_reset();
    push_frame(0, 1'b1, 256);
    push_frame(0, 1'b1, 256);
    run(6000);
    check_val("win_count_random", WW'(win_cnt), WW'(392));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
